// File: rtl/fifo_pkg.sv
// Shared definitions for both halves of the dual-clock FIFO: default sizes and
// the binary/Gray pointer conversions used by the read and write controllers.
package fifo_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 32'd3;
   localparam int DATA_WIDTH_DEFAULT = 32'd10;

   // Conversions work on a wide word; callers zero-extend and keep the low bits.
   typedef logic [31:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return (bin >> 1) ^ bin;
   endfunction

   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module gray_sync #(
   parameter int WIDTH       = 32'd4,
   parameter int SYNC_STAGES = 32'd2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] stage_r [SYNC_STAGES];

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign sync_out = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointers, RAM addressing,
// registered read data and empty / almost-empty / occupancy / underflow status.
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
   parameter int SYNC_STAGES = 32'd2,
   parameter int AE_THRESH   = 32'd1
) (
   input  logic                  read_clk,
   input  logic                  read_rst,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH:0]   write_gray_pointer,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic [ADDR_WIDTH:0]   read_pointer,
   output logic [ADDR_WIDTH:0]   read_gray_pointer,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic                  underflow
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0]      read_pointer_r;
   logic [PTR_W-1:0]      read_gray_pointer_r;
   logic [DATA_WIDTH-1:0] read_data_r;
   logic                  read_valid_r;
   logic                  empty_r;
   logic                  almost_empty_r;
   logic [PTR_W-1:0]      occupancy_r;
   logic                  underflow_r;

   logic [PTR_W-1:0]      wgray_sync_s;
   logic                  accept_s;
   logic [PTR_W-1:0]      rbin_next_s;
   logic [PTR_W-1:0]      rgray_next_s;
   logic [PTR_W-1:0]      wbin_sync_s;
   logic [PTR_W-1:0]      occ_next_s;
   logic                  ae_next_s;
   ptr_word_t             rgray_word_s;
   ptr_word_t             wbin_word_s;

   gray_sync #(
      .WIDTH       (PTR_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk      (read_clk),
      .rst      (read_rst),
      .async_in (write_gray_pointer),
      .sync_out (wgray_sync_s)
   );

   // Next-pointer and status arithmetic; status is derived from the pointer after this edge.
   always_comb begin
      accept_s     = read_enable & ~empty_r;
      rbin_next_s  = read_pointer_r + PTR_W'(accept_s);
      rgray_word_s = bin2gray(ptr_word_t'(rbin_next_s));
      rgray_next_s = rgray_word_s[PTR_W-1:0];
      wbin_word_s  = gray2bin(ptr_word_t'(wgray_sync_s));
      wbin_sync_s  = wbin_word_s[PTR_W-1:0];
      occ_next_s   = wbin_sync_s - rbin_next_s;
      ae_next_s    = (occ_next_s <= PTR_W'(AE_THRESH));
   end

   // Pointer, status and data registers.
   always_ff @(posedge read_clk) begin
      if (read_rst) begin
         read_pointer_r      <= {PTR_W{1'b0}};
         read_gray_pointer_r <= {PTR_W{1'b0}};
         read_data_r         <= {DATA_WIDTH{1'b0}};
         read_valid_r        <= 1'b0;
         empty_r             <= 1'b1;
         almost_empty_r      <= 1'b1;
         occupancy_r         <= {PTR_W{1'b0}};
         underflow_r         <= 1'b0;
      end else begin
         read_pointer_r      <= rbin_next_s;
         read_gray_pointer_r <= rgray_next_s;
         empty_r             <= (rgray_next_s == wgray_sync_s);
         almost_empty_r      <= ae_next_s;
         occupancy_r         <= occ_next_s;
         if (accept_s) begin
            read_data_r  <= mem_rdata;
            read_valid_r <= 1'b1;
         end else begin
            read_data_r  <= read_data_r;
            read_valid_r <= 1'b0;
         end
         // Sticky until reset.
         if (read_enable & empty_r) begin
            underflow_r <= 1'b1;
         end else begin
            underflow_r <= underflow_r;
         end
      end
   end

   assign read_addr         = read_pointer_r[ADDR_WIDTH-1:0];
   assign read_pointer      = read_pointer_r;
   assign read_gray_pointer = read_gray_pointer_r;
   assign read_data         = read_data_r;
   assign read_valid        = read_valid_r;
   assign empty             = empty_r;
   assign almost_empty      = almost_empty_r;
   assign occupancy         = occupancy_r;
   assign underflow         = underflow_r;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: the bench plays RAM and writer, and a
// scoreboard queue holds the words expected on read_data.
module tb_fifo_read_ctrl;

   localparam int AW = 3;
   localparam int DW = 10;

   localparam logic [3:0] GRAY_TAB [16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   logic          read_clk = 1'b0;
   logic          read_rst;
   logic          read_enable;
   logic [AW:0]   write_gray_pointer;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] read_addr;
   logic [AW:0]   read_pointer;
   logic [AW:0]   read_gray_pointer;
   logic [DW-1:0] read_data;
   logic          read_valid;
   logic          empty;
   logic          almost_empty;
   logic [AW:0]   occupancy;
   logic          underflow;

   logic [DW-1:0] mem [8];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] mon_exp;
   int checks = 0;
   int errors = 0;

   always #5 read_clk = ~read_clk;

   assign mem_rdata = mem[read_addr];

   fifo_read_ctrl dut (
      .read_clk           (read_clk),
      .read_rst           (read_rst),
      .read_enable        (read_enable),
      .write_gray_pointer (write_gray_pointer),
      .mem_rdata          (mem_rdata),
      .read_addr          (read_addr),
      .read_pointer       (read_pointer),
      .read_gray_pointer  (read_gray_pointer),
      .read_data          (read_data),
      .read_valid         (read_valid),
      .empty              (empty),
      .almost_empty       (almost_empty),
      .occupancy          (occupancy),
      .underflow          (underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge read_clk);
      #1;
   endtask

   // Scoreboard monitor: every read_valid pulse must match the oldest expected word.
   always @(negedge read_clk) begin
      if (read_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: read_data %h with no word expected", read_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (read_data !== mon_exp) begin
               errors++;
               $display("FAIL read_data: got %h expected %h", read_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      read_rst           = 1'b1;
      read_enable        = 1'b0;
      write_gray_pointer = 4'b0000;
      for (int i = 0; i < 8; i++) mem[i] = 10'h000;
      step();
      step();
      read_rst = 1'b0;

      // Reset then idle.
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_empty", 32'(empty), 32'd1);
         chk("idle_ae", 32'(almost_empty), 32'd1);
         chk("idle_occ", 32'(occupancy), 32'd0);
         chk("idle_valid", 32'(read_valid), 32'd0);
      end

      // Write pointer steps to 2: empty falls on the third edge.
      mem[0] = 10'h155;
      mem[1] = 10'h2AA;
      write_gray_pointer = 4'b0011;
      step();
      chk("sync_edge1_empty", 32'(empty), 32'd1);
      step();
      chk("sync_edge2_empty", 32'(empty), 32'd1);
      step();
      chk("sync_edge3_empty", 32'(empty), 32'd0);
      chk("sync_edge3_occ", 32'(occupancy), 32'd2);
      chk("sync_edge3_ae", 32'(almost_empty), 32'd0);

      // Two back-to-back reads.
      exp_q.push_back(10'h155);
      exp_q.push_back(10'h2AA);
      read_enable = 1'b1;
      step();
      chk("rd1_occ", 32'(occupancy), 32'd1);
      chk("rd1_ae", 32'(almost_empty), 32'd1);
      step();
      read_enable = 1'b0;
      chk("rd2_empty", 32'(empty), 32'd1);
      chk("rd2_ptr", 32'(read_pointer), 32'd2);
      chk("rd2_gray", 32'(read_gray_pointer), 32'b0011);
      chk("rd2_underflow", 32'(underflow), 32'd0);

      // Reading while empty sets sticky underflow, pointer stays.
      read_enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("uf_flag", 32'(underflow), 32'd1);
         chk("uf_ptr", 32'(read_pointer), 32'd2);
      end
      read_enable = 1'b0;
      step();
      step();
      chk("uf_sticky", 32'(underflow), 32'd1);

      // Reset in the middle of a read burst.
      for (int i = 2; i < 6; i++) mem[i] = 10'h0A0 + 10'(i);
      write_gray_pointer = 4'b0101;
      for (int i = 0; i < 4; i++) step();
      chk("burst_occ", 32'(occupancy), 32'd4);
      exp_q.push_back(10'h0A2);
      exp_q.push_back(10'h0A3);
      read_enable = 1'b1;
      step();
      step();
      read_rst = 1'b1;
      write_gray_pointer = 4'b0000;
      step();
      chk("rst_ptr", 32'(read_pointer), 32'd0);
      chk("rst_gray", 32'(read_gray_pointer), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_valid", 32'(read_valid), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      read_rst    = 1'b0;
      read_enable = 1'b0;
      step();

      // Stream 16 words: first pass of 8.
      for (int i = 0; i < 8; i++) mem[i] = 10'h200 + 10'(i);
      write_gray_pointer = 4'b1100;
      for (int i = 0; i < 3; i++) step();
      chk("p1_occ", 32'(occupancy), 32'd8);
      chk("p1_empty", 32'(empty), 32'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back(10'h200 + 10'(i));
      read_enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("p1_ptr", 32'(read_pointer), 32'(k + 1));
         chk("p1_gray", 32'(read_gray_pointer), 32'(GRAY_TAB[k + 1]));
         if (k < 7) chk("p1_not_empty", 32'(empty), 32'd0);
      end
      read_enable = 1'b0;
      chk("p1_end_empty", 32'(empty), 32'd1);

      // Second pass: 4 words ready, rest arrive while reading.
      for (int i = 0; i < 8; i++) mem[i] = 10'h300 + 10'(i);
      write_gray_pointer = 4'b1010;
      for (int i = 0; i < 3; i++) step();
      chk("p2_occ", 32'(occupancy), 32'd4);
      for (int i = 0; i < 8; i++) exp_q.push_back(10'h300 + 10'(i));
      read_enable = 1'b1;
      write_gray_pointer = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("p2_ptr", 32'(read_pointer), 32'((9 + k) % 16));
         chk("p2_gray", 32'(read_gray_pointer), 32'(GRAY_TAB[(9 + k) % 16]));
         chk("p2_addr", 32'(read_addr), 32'((9 + k) % 8));
         if (k == 2) chk("p2_occ_simul", 32'(occupancy), 32'd5);
      end
      read_enable = 1'b0;
      chk("p2_end_empty", 32'(empty), 32'd1);
      chk("p2_end_occ", 32'(occupancy), 32'd0);
      chk("p2_end_underflow", 32'(underflow), 32'd0);

      step();
      step();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
